// File: rtl/accel_seq.sv
// Power/run sequencer for the tile accelerator core: power-up delay, isolation control,
// job launch on a start edge, and a watchdog that forces a finish on a hung job.
module accel_seq #(
  parameter int PWRUP_CYCLES   = 16,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sw_on_i,
  input  logic       start_i,
  output logic       rdy_o,
  output logic       int_fin_o,
  output logic       timeout_o,
  output logic       core_pwr_en_o,
  output logic       core_iso_o,
  output logic       core_start_o,
  input  logic       core_done_i,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    PWRUP = 3'd1,
    IDLE  = 3'd2,
    RUN   = 3'd3,
    FIN   = 3'd4,
    PWRDN = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(PWRUP_CYCLES - 1);
  // With the watchdog disabled the compare value is never used.
  localparam logic [TO_W-1:0]  TCNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);
  localparam bit               WDOG_EN   = (TIMEOUT_CYCLES != 0);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  pcnt_reg, pcnt_next;
  logic [TO_W-1:0]   tcnt_reg, tcnt_next;
  logic              timeout_reg, timeout_next;
  logic              start_pulse_reg, start_pulse_next;
  logic              start_q_reg;
  logic              start_rise;

  assign start_rise = start_i & ~start_q_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= OFF;
      pcnt_reg        <= '0;
      tcnt_reg        <= '0;
      timeout_reg     <= 1'b0;
      start_pulse_reg <= 1'b0;
      start_q_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pcnt_reg        <= pcnt_next;
      tcnt_reg        <= tcnt_next;
      timeout_reg     <= timeout_next;
      start_pulse_reg <= start_pulse_next;
      start_q_reg     <= start_i;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pcnt_next        = pcnt_reg;
    tcnt_next        = tcnt_reg;
    timeout_next     = timeout_reg;
    start_pulse_next = 1'b0;
    case (state_reg)
      OFF: begin
        if (sw_on_i) begin
          state_next = PWRUP;
          pcnt_next  = '0;
        end
      end
      PWRUP: begin
        pcnt_next = pcnt_reg + CNT_W'(1);
        if (!sw_on_i)                    state_next = PWRDN;
        else if (pcnt_reg == PCNT_LAST)  state_next = IDLE;
      end
      IDLE: begin
        // Power-down request outranks a simultaneous job request.
        if (!sw_on_i) begin
          state_next = PWRDN;
        end else if (start_rise) begin
          state_next       = RUN;
          start_pulse_next = 1'b1;
          tcnt_next        = '0;
          timeout_next     = 1'b0;
        end
      end
      RUN: begin
        tcnt_next = tcnt_reg + TO_W'(1);
        if (core_done_i) begin
          state_next = FIN;
        end else if (WDOG_EN && (tcnt_reg == TCNT_LAST)) begin
          state_next   = FIN;
          timeout_next = 1'b1;
        end
      end
      FIN:     state_next = sw_on_i ? IDLE : PWRDN;
      PWRDN:   state_next = OFF;
      default: state_next = OFF;
    endcase
  end

  assign rdy_o         = (state_reg == IDLE);
  assign int_fin_o     = (state_reg == FIN);
  assign timeout_o     = timeout_reg;
  assign core_pwr_en_o = (state_reg == PWRUP) || (state_reg == IDLE) || (state_reg == RUN) ||
                         (state_reg == FIN)   || (state_reg == PWRDN);
  assign core_iso_o    = !((state_reg == IDLE) || (state_reg == RUN) || (state_reg == FIN));
  assign core_start_o  = start_pulse_reg;
  assign state_o       = state_reg;

endmodule

// File: tb/tb_accel_seq.sv
// Self-checking bench for accel_seq: scoreboard of per-job finish latency and timeout flag,
// plus direct checks of the power sequencing, start-edge handling and async reset.
module tb_accel_seq;

  localparam int PW = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n, sw_on, start, done;
  logic       rdy, int_fin, timeout, pwr_en, iso, core_start;
  logic [2:0] state;

  always #5 clk = ~clk;

  accel_seq #(
    .PWRUP_CYCLES(PW), .CNT_W(8), .TIMEOUT_CYCLES(TO), .TO_W(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .sw_on_i(sw_on), .start_i(start),
    .rdy_o(rdy), .int_fin_o(int_fin), .timeout_o(timeout),
    .core_pwr_en_o(pwr_en), .core_iso_o(iso), .core_start_o(core_start),
    .core_done_i(done), .state_o(state)
  );

  typedef struct packed {
    logic [31:0] lat;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   fin_count = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: measures cycles from core_start_o to int_fin_o and scores each finished job.
  initial begin
    int   since;
    exp_t e;
    since = 0;
    forever begin
      tick();
      if (core_start) since = 0;
      else            since++;
      if (int_fin) begin
        fin_count++;
        if (sb_q.size() == 0) begin
          chk("fin_unexpected", 32'(int_fin), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("fin_latency", since, e.lat);
          chk("fin_timeout", 32'(timeout), 32'(e.to));
          $display("[TB] job finished latency=%0d timeout=%0d", since, timeout);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic power_up();
    sw_on = 1'b1;
    tick();
    chk("pu_c1_pwr_en", 32'(pwr_en), 32'd1);
    chk("pu_c1_iso",    32'(iso),    32'd1);
    chk("pu_c1_state",  32'(state),  32'd1);
    repeat (PW - 1) tick();
    chk("pu_c4_iso", 32'(iso), 32'd1);
    chk("pu_c4_rdy", 32'(rdy), 32'd0);
    tick();
    chk("pu_c5_rdy",   32'(rdy),   32'd1);
    chk("pu_c5_iso",   32'(iso),   32'd0);
    chk("pu_c5_state", 32'(state), 32'd2);
  endtask

  // d: RUN cycle index (>=1) in which done is presented; use_done=0 lets the watchdog fire.
  task automatic run_job(input int d, input bit use_done, input bit drop_sw);
    exp_t e;
    e.lat = use_done ? 32'(d + 1) : 32'(TO);
    e.to  = use_done ? 1'b0 : 1'b1;
    sb_q.push_back(e);
    start = 1'b1;
    tick();
    chk("job_strobe",   32'(core_start), 32'd1);
    chk("job_rdy_low",  32'(rdy),        32'd0);
    chk("job_to_clear", 32'(timeout),    32'd0);
    chk("job_state",    32'(state),      32'd3);
    start = 1'b0;
    if (drop_sw) sw_on = 1'b0;
    tick();
    chk("job_strobe_1cyc", 32'(core_start), 32'd0);
    if (use_done) begin
      repeat (d - 1) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
    end else begin
      repeat (TO - 1) tick();
    end
    chk("fin_pulse",   32'(int_fin), 32'd1);
    chk("fin_rdy_low", 32'(rdy),     32'd0);
    tick();
    chk("fin_pulse_end", 32'(int_fin), 32'd0);
    if (drop_sw) begin
      chk("pd_iso",    32'(iso),    32'd1);
      chk("pd_pwr_en", 32'(pwr_en), 32'd1);
      chk("pd_state",  32'(state),  32'd5);
      tick();
      chk("off_pwr_en", 32'(pwr_en), 32'd0);
      chk("off_iso",    32'(iso),    32'd1);
      chk("off_state",  32'(state),  32'd0);
    end else begin
      chk("fin_rdy_back", 32'(rdy),   32'd1);
      chk("fin_idle",     32'(state), 32'd2);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},   32'(state),      32'd0);
    chk({tag, "_rdy"},     32'(rdy),        32'd0);
    chk({tag, "_fin"},     32'(int_fin),    32'd0);
    chk({tag, "_timeout"}, 32'(timeout),    32'd0);
    chk({tag, "_pwr_en"},  32'(pwr_en),     32'd0);
    chk({tag, "_iso"},     32'(iso),        32'd1);
    chk({tag, "_start"},   32'(core_start), 32'd0);
  endtask

  initial begin
    int fin_snap;
    rst_n = 1'b0; sw_on = 1'b0; start = 1'b0; done = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    chk("off_hold", 32'(state), 32'd0);

    power_up();
    run_job(5, 1'b1, 1'b0);                    // normal completion
    run_job(0, 1'b0, 1'b0);                    // watchdog timeout
    chk("to_sticky", 32'(timeout), 32'd1);
    tick();
    chk("to_sticky2", 32'(timeout), 32'd1);
    run_job(3, 1'b1, 1'b0);                    // start edge clears timeout
    run_job(0, 1'b0, 1'b0);
    run_job(7, 1'b1, 1'b0);                    // done on last watchdog cycle wins
    run_job(2, 1'b1, 1'b1);                    // sw_on dropped mid-job

    // start held through power-up must not launch a job
    sw_on = 1'b1; start = 1'b1;
    repeat (PW + 1) tick();
    chk("held_idle", 32'(state), 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("held_no_strobe", 32'(core_start), 32'd0);
      chk("held_stay_idle", 32'(state),      32'd2);
      tick();
    end
    start = 1'b0;
    tick();

    // async reset during RUN
    start = 1'b1;
    tick();
    chk("rst_job_strobe", 32'(core_start), 32'd1);
    start = 1'b0;
    tick(); tick();
    fin_snap = fin_count;
    rst_n = 1'b0; sw_on = 1'b0;
    #1;
    chk_reset_vals("async");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("async_off", 32'(state), 32'd0);
    chk("async_no_fin", 32'(fin_count), 32'(fin_snap));

    power_up();
    run_job(4, 1'b1, 1'b0);
    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
